// File: rtl/shift_add_multiplier_if.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier_if
// Request/response bundle between a requester and the shift-add multiplier.
//   start         : request a multiply (honoured only while the multiplier idles)
//   multiplicand  : operand M, WIDTH bits
//   multiplier    : operand Q, WIDTH bits
//   busy          : multiplier is iterating
//   done          : one-cycle completion strobe, product valid alongside it
//   product       : 2*WIDTH-bit result, held until the next completion
// master modport = requester side, slave modport = multiplier side.
// ----------------------------------------------------------------------------
interface shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential unsigned WIDTH x WIDTH multiplier, right-shift shift-and-add form.
// One conditional add plus one right shift of {carry, A, Q} per clock; the
// add runs through a ripple-carry chain of fulladder cells.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous, active-high reset
//   mul_if  : slave side of shift_add_multiplier_if (start, operands,
//             busy, done, product); all outputs are registered.
// ----------------------------------------------------------------------------

// Single-bit full adder cell used to build the ripple-carry chain.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_add_multiplier_if.slave  mul_if
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH:0]       carry_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   shifted_s;

    // Multiplicand is added only when the current multiplier LSB is set.
    assign addend_s   = q_q[0] ? m_q : {WIDTH{1'b0}};
    assign carry_s[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rca
            fulladder u_fa (
                .a_i    (a_q[gi]),
                .b_i    (addend_s[gi]),
                .cin_i  (carry_s[gi]),
                .sum_o  (sum_s[gi]),
                .cout_o (carry_s[gi+1])
            );
        end
    endgenerate

    // The carry-out becomes the new MSB of A; without it large products wrap.
    assign sum_s[WIDTH] = carry_s[WIDTH];
    // Logical right shift of {carry, A, Q}: the Q LSB just consumed drops out.
    assign shifted_s    = {sum_s, q_q[WIDTH-1:1]};

    // Next-state, datapath and output decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mul_if.start) begin
                    m_d     = mul_if.multiplicand;
                    q_d     = mul_if.multiplier;
                    a_d     = {WIDTH{1'b0}};
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = shifted_s[2*WIDTH-1:WIDTH];
                q_d   = shifted_s[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                // Counter at 1 marks the final iteration: publish the result.
                if (cnt_q == CW'(1)) begin
                    product_d = shifted_s;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= {WIDTH{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mul_if.busy    = busy_q;
    assign mul_if.done    = done_q;
    assign mul_if.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// tb_shift_add_multiplier
// Directed stimulus pushes expected products into a scoreboard queue; a
// monitor on the falling edge pops and compares whenever done is seen, and
// also checks latency and busy duration per operation.
// ----------------------------------------------------------------------------
module tb_shift_add_multiplier;
    localparam int W = 32;

    typedef struct {
        logic [63:0] exp;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic rst;
    int unsigned cyc;
    int n_checks;
    int n_pass;
    int busy_cnt;
    logic prev_done;
    exp_t sb[$];

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .mul_if (bus.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: scoreboard compare on each done strobe.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                check("done_one_cycle", 64'(prev_done), 64'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got done=1 expected no done, product 0x%0h", bus.product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", bus.product, e.exp);
                    check("latency", 64'(cyc - e.cyc), 64'd32);
                    check("busy_cycles", 64'(busy_cnt), 64'd32);
                end
                busy_cnt = 0;
            end
            prev_done = bus.done;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        exp_t e;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(posedge clk);
        #1;
        e.exp = exp;
        e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    logic [31:0] dir_a [4] = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    logic [31:0] dir_b [4] = '{32'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'd2};
    logic [63:0] dir_p [4] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFE_0000_0001,
                               64'h0, 64'h0000_0001_0000_0000};

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = 32'd0;
        bus.multiplier   = 32'd0;

        // Reset for two cycles, check idle outputs.
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_product", bus.product, 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Directed products including carry-retention corners.
        for (int i = 0; i < 4; i++) begin
            issue(dir_a[i], dir_b[i], dir_p[i]);
            drain();
        end

        // Start and operand changes during RUN are ignored.
        issue(32'd7, 32'd6, 64'd42);
        repeat (8) @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 32'd100;
        bus.multiplier   = 32'd100;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.multiplicand = 32'h5555_AAAA;
        bus.multiplier   = 32'h1234_0000;
        drain();

        // Reset mid-operation aborts without a done.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 32'h1234_5678;
        bus.multiplier   = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #10 rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_product", bus.product, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_product_hold", bus.product, 64'd0);
        issue(32'd2, 32'd3, 64'd6);
        drain();

        // Back-to-back with start held high: one accept every 34 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            exp_t e;
            a = $urandom;
            b = $urandom;
            if (i == 0) a = 32'hFFFF_FFFF;
            bus.multiplicand = a;
            bus.multiplier   = b;
            @(posedge clk);
            #1;
            e.exp = {32'd0, a} * {32'd0, b};
            e.cyc = cyc;
            sb.push_back(e);
            @(negedge clk);
            bus.multiplicand = $urandom;
            bus.multiplier   = $urandom;
            repeat (33) @(negedge clk);
        end
        bus.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
